// File: rtl/fetch_pc_sequencer.sv
// Next-PC controller for the 5-stage pipeline: arbitrates trap, EX redirect, load-use and
// instruction-memory wait, and drives the PC register plus IF/ID and ID/EX stall/flush controls.
module fetch_pc_sequencer #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter logic [XLEN-1:0]      TRAP_VEC = XLEN'(32'h0000_0100),
  parameter int unsigned          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_cur,
  output logic [XLEN-1:0]  pc_next,
  output logic             stall_pc,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic             load_use_hazard,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] held_q, held_d;
  logic            held_trap_q, held_trap_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [XLEN-1:0] redirect_aligned;
  logic [XLEN-1:0] event_target;

  assign redirect_aligned = {redirect_target[XLEN-1:2], 2'b00};
  assign event_target     = trap_valid ? TRAP_VEC : redirect_aligned;

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    held_trap_d = held_trap_q;
    pc_next     = pc_cur;
    stall_pc    = 1'b1;
    imem_req    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b1;
    flush_id_ex = 1'b1;

    if (reset) begin
      pc_next     = RESET_PC;
      state_d     = StBoot;
      held_d      = '0;
      held_trap_d = 1'b0;
    end else begin
      case (state_q)
        StBoot: state_d = StRun;

        StRun: begin
          imem_req = 1'b1;
          if (trap_valid || redirect_valid) begin
            if (imem_ready) begin
              pc_next  = event_target;
              stall_pc = 1'b0;
            end else begin
              // Fetch still in flight: park the target until it completes.
              held_d      = event_target;
              held_trap_d = trap_valid;
              state_d     = StHold;
            end
          end else if (load_use_hazard) begin
            stall_if_id = 1'b1;
            flush_if_id = 1'b0;
          end else if (!imem_ready) begin
            flush_id_ex = 1'b0;
          end else begin
            pc_next     = pc_cur + XLEN'(4);
            stall_pc    = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
          end
        end

        StHold: begin
          imem_req = 1'b1;
          // A latched trap target cannot be displaced by a later redirect.
          if (trap_valid) begin
            held_d      = TRAP_VEC;
            held_trap_d = 1'b1;
          end else if (redirect_valid && !held_trap_q) begin
            held_d = redirect_aligned;
          end
          if (imem_ready) begin
            pc_next     = trap_valid ? TRAP_VEC : held_q;
            stall_pc    = 1'b0;
            held_trap_d = 1'b0;
            state_d     = StRun;
          end
        end

        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    held_q      <= held_d;
    held_trap_q <= held_trap_d;
  end

  // Saturating count of PC-hold cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Next-PC controller for the 5-stage RISC-V pipeline; drives PC_in and stall_PC of the PC register.
- Arbitrates between four sources of PC change: trap vector, EX-stage branch/jump redirect, load-use stall, and instruction-memory wait.
- Also generates the IF/ID and ID/EX stall/flush controls and a stall-cycle performance counter.

Parameters:
- XLEN, 32, address width.
- RESET_PC, 32'h0000_0000, boot address; equals the PC register's reset value.
- TRAP_VEC, 32'h0000_0100, trap handler address.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  sync reset.
- pc_cur  in  XLEN  PC register output (current fetch PC).
- pc_next  out  XLEN  to PC register PC_in.
- stall_pc  out  1  to PC register stall_PC; 1 = hold PC.
- imem_req  out  1  fetch request for pc_cur.
- imem_ready  in  1  fetch for pc_cur completes this cycle.
- load_use_hazard  in  1  from ID hazard unit, level.
- redirect_valid  in  1  one-cycle pulse from EX, branch taken or jump.
- redirect_target  in  XLEN  redirect address, valid with redirect_valid.
- trap_valid  in  1  one-cycle pulse, exception/ecall.
- stall_if_id  out  1  hold IF/ID register.
- flush_if_id  out  1  bubble IF/ID.
- flush_id_ex  out  1  bubble ID/EX.
- stall_cycles  out  CNT_W  count of cycles with stall_pc=1.

Behaviour:
- Reset is `reset`, synchronous, active-high. Clock is `clk`.
- While reset=1:
  - state <= BOOT; stall_cycles <= 0; held target <= 0.
  - Outputs forced: pc_next=RESET_PC, stall_pc=1, imem_req=0, flush_if_id=1, flush_id_ex=1, stall_if_id=0.
- States:
  - BOOT: one cycle after reset deasserts. imem_req=0, stall_pc=1, both flushes=1. Goes to RUN unconditionally. A trap or redirect in BOOT is ignored.
  - RUN: imem_req=1. Combinational priority is trap > redirect > load-use > imem wait > sequential.
    - Trap: if imem_ready=1, pc_next=TRAP_VEC, stall_pc=0, flush_if_id=1, flush_id_ex=1. Otherwise latch TRAP_VEC into the held target, stall_pc=1, both flushes=1, go to HOLD.
    - Redirect: same as trap, with target = {redirect_target[XLEN-1:2],2'b00}. Bits [1:0] are always cleared.
    - Load-use, with no trap/redirect: stall_pc=1, stall_if_id=1, flush_if_id=0, flush_id_ex=1. imem_ready is don't-care; the fetch result is held in IF/ID by stall_if_id.
    - imem_ready=0, with no higher event: stall_pc=1, flush_if_id=1, stall_if_id=0, flush_id_ex=0.
    - Otherwise: pc_next=pc_cur+4 (mod 2^XLEN, wraps), stall_pc=0, all stall/flush=0.
  - HOLD: an in-flight fetch is never abandoned.
    - imem_req=1, stall_pc=1, flush_if_id=1, flush_id_ex=1. load_use_hazard is ignored.
    - A new trap overwrites the held target with TRAP_VEC.
    - A new redirect overwrites the held target only if the held target is not TRAP_VEC-from-trap; a trap flag is latched for this.
    - On imem_ready=1: pc_next=held target (or TRAP_VEC if trap_valid this cycle), stall_pc=0, flush_if_id=1, go to RUN.
- When stall_pc=0, pc_next is the value loaded into the PC register at the next edge. When stall_pc=1, pc_next is pc_cur (don't-care for the PC register, but driven to pc_cur for determinism).
- stall_cycles increments every cycle stall_pc=1 and reset=0, including BOOT. It saturates at all-ones and never wraps.
- All outputs except stall_cycles are combinational from state, the registered held target, and inputs. No input-to-output path goes through a PC-register loop.

Test Plan:
- Reset 3 cycles, then imem_ready=1 constant:
  - PC sequence 0, 0 (BOOT), 4, 8, 0xC.
  - stall_cycles=1 after BOOT.
- In RUN at pc_cur=0x20, load_use_hazard=1 for 1 cycle:
  - stall_pc=1, stall_if_id=1, flush_id_ex=1, flush_if_id=0.
  - Next cycle pc_next=0x24.
- redirect_valid with target 0x83, imem_ready=1:
  - pc_next=0x80, stall_pc=0, both flushes=1.
  - Next pc_cur=0x80, simultaneous load_use_hazard ignored.
- Redirect to 0x200 while imem_ready=0 for 3 cycles:
  - State HOLD, stall_pc=1 for 3 cycles.
  - On ready, pc_next=0x200.
  - stall_cycles advanced by 3.
- Trap and redirect (0x400) in the same cycle, imem_ready=1:
  - pc_next=0x100.
- In HOLD with trap latched:
  - A redirect to 0x500 arrives and is ignored; pc_next=0x100 on ready.
- reset asserted mid-HOLD:
  - Next cycle state BOOT, held target cleared, pc_next=0.
  - Fetch resumes at 0 two cycles after release.
- CNT_W=4, imem_ready=0 for 20 cycles:
  - stall_cycles saturates at 15.
- Sequential wrap: pc_cur=0xFFFF_FFFC, imem_ready=1:
  - pc_next=0x0000_0000.
